// File: rtl/spi_slave_rx_tx.sv
// SPI responder working entirely in the pclk domain: oversamples ss/sclk/mosi, shifts a byte out
// on miso while assembling one from mosi, with a one-byte TX holding buffer and RX valid/overrun flags.
module spi_slave_rx_tx #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 8
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              ss,
    input  logic              sclk,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsbfe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ack,
    output logic              rx_overrun,
    input  logic              ovr_clr,
    output logic              busy
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [2:0] pin_vec;
    logic [2:0] pin_sync;
    assign pin_vec = {mosi, sclk, ss};

    // Chains clear to 0 so a select that is already low out of reset never looks like a fall;
    // ss must be seen high before a frame can start.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_reg;
            always_ff @(posedge pclk) begin
                if (preset)
                    chain_reg <= '0;
                else
                    chain_reg <= (chain_reg << 1) | SYNC_STAGES'(pin_vec[gi]);
            end
            assign pin_sync[gi] = chain_reg[SYNC_STAGES-1];
        end
    endgenerate

    state_t             state_reg;
    logic               ss_prev_reg, sclk_prev_reg;
    logic               cpol_reg, cpha_reg, lsbfe_reg;
    logic [CNT_W-1:0]   bit_cnt_reg, tx_idx_reg;
    logic               tx_pend_reg;
    logic [DATA_W-1:0]  tx_byte_reg, rx_asm_reg;
    logic               miso_reg, miso_oe_reg, busy_reg;
    logic [DATA_W-1:0]  rx_data_reg, tx_buf_reg;
    logic               rx_valid_reg, rx_ovr_reg, tx_full_reg;

    logic ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic byte_done, load_now, tx_take;
    logic [DATA_W-1:0] load_byte, rx_byte_next;
    logic [CNT_W-1:0]  tx_idx_next;

    assign ss_fall     = ss_prev_reg & ~pin_sync[0];
    assign ss_rise     = ~ss_prev_reg & pin_sync[0];
    assign sclk_rise   = ~sclk_prev_reg & pin_sync[1];
    assign sclk_fall   = sclk_prev_reg & ~pin_sync[1];
    assign lead_edge   = cpol_reg ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol_reg ? sclk_rise : sclk_fall;
    assign sample_edge = cpha_reg ? trail_edge : lead_edge;
    assign shift_edge  = cpha_reg ? lead_edge : trail_edge;

    function automatic logic [CNT_W-1:0] bit_pos(input logic lsb, input logic [CNT_W-1:0] k);
        return lsb ? k : (CNT_W'(DATA_W - 1) - k);
    endfunction

    assign byte_done   = (state_reg == ACTIVE) && !ss_rise && sample_edge &&
                         (bit_cnt_reg == CNT_W'(DATA_W - 1));
    assign load_now    = ((state_reg == IDLE) && ss_fall) || byte_done;
    assign tx_take     = load_now && tx_full_reg;
    assign load_byte   = tx_full_reg ? tx_buf_reg : '0;
    assign tx_idx_next = tx_idx_reg + CNT_W'(1);

    always_comb begin
        rx_byte_next = rx_asm_reg;
        rx_byte_next[bit_pos(lsbfe_reg, bit_cnt_reg)] = pin_sync[2];
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_reg     <= IDLE;
            ss_prev_reg   <= 1'b0;
            sclk_prev_reg <= 1'b0;
            cpol_reg      <= 1'b0;
            cpha_reg      <= 1'b0;
            lsbfe_reg     <= 1'b0;
            bit_cnt_reg   <= '0;
            tx_idx_reg    <= '0;
            tx_pend_reg   <= 1'b0;
            tx_byte_reg   <= '0;
            rx_asm_reg    <= '0;
            miso_reg      <= 1'b0;
            miso_oe_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            rx_ovr_reg    <= 1'b0;
            tx_buf_reg    <= '0;
            tx_full_reg   <= 1'b0;
        end else begin
            ss_prev_reg   <= pin_sync[0];
            sclk_prev_reg <= pin_sync[1];

            // Writes are only accepted while empty, so write and consume never collide on one byte.
            if (tx_valid && !tx_full_reg) begin
                tx_buf_reg  <= tx_data;
                tx_full_reg <= 1'b1;
            end else if (tx_take) begin
                tx_full_reg <= 1'b0;
            end

            if (byte_done)
                rx_valid_reg <= 1'b1;
            else if (rx_ack)
                rx_valid_reg <= 1'b0;

            if (byte_done && rx_valid_reg && !rx_ack)
                rx_ovr_reg <= 1'b1;
            else if (ovr_clr)
                rx_ovr_reg <= 1'b0;

            if (byte_done)
                rx_data_reg <= rx_byte_next;

            case (state_reg)
                IDLE: begin
                    if (ss_fall) begin
                        state_reg   <= ACTIVE;
                        cpol_reg    <= cpol;
                        cpha_reg    <= cpha;
                        lsbfe_reg   <= lsbfe;
                        busy_reg    <= 1'b1;
                        miso_oe_reg <= 1'b1;
                        bit_cnt_reg <= '0;
                        rx_asm_reg  <= '0;
                        tx_byte_reg <= load_byte;
                        tx_idx_reg  <= '0;
                        // With cpha=1 the first shift edge re-presents bit 0 instead of advancing.
                        tx_pend_reg <= cpha;
                        miso_reg    <= load_byte[bit_pos(lsbfe, CNT_W'(0))];
                    end
                end
                ACTIVE: begin
                    if (ss_rise) begin
                        state_reg   <= IDLE;
                        miso_reg    <= 1'b0;
                        miso_oe_reg <= 1'b0;
                        busy_reg    <= 1'b0;
                        bit_cnt_reg <= '0;
                    end else begin
                        if (sample_edge) begin
                            if (byte_done) begin
                                bit_cnt_reg <= '0;
                                rx_asm_reg  <= '0;
                                tx_byte_reg <= load_byte;
                                tx_pend_reg <= 1'b1;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                                rx_asm_reg  <= rx_byte_next;
                            end
                        end
                        if (shift_edge) begin
                            if (tx_pend_reg) begin
                                tx_idx_reg  <= '0;
                                tx_pend_reg <= 1'b0;
                                miso_reg    <= tx_byte_reg[bit_pos(lsbfe_reg, CNT_W'(0))];
                            end else begin
                                tx_idx_reg  <= tx_idx_next;
                                miso_reg    <= tx_byte_reg[bit_pos(lsbfe_reg, tx_idx_next)];
                            end
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign miso       = miso_reg;
    assign miso_oe    = miso_oe_reg;
    assign busy       = busy_reg;
    assign tx_ready   = ~tx_full_reg;
    assign rx_data    = rx_data_reg;
    assign rx_valid   = rx_valid_reg;
    assign rx_overrun = rx_ovr_reg;
endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Bench for spi_slave_rx_tx: bit-bangs an SPI master in all modes and compares miso bits,
// received bytes and buffer/flag behaviour against a byte-level model of the responder.
module tb_spi_slave_rx_tx;
    localparam int H = 6;

    logic       pclk = 1'b0;
    logic       preset, ss, sclk, mosi, miso, miso_oe, cpol, cpha, lsbfe;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid, tx_ready, rx_valid, rx_ack, rx_overrun, ovr_clr, busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Byte-level model: TX holding buffer, RX pending/overrun flags, byte currently being sent.
    bit       m_full, m_pending, m_ovr, dead_f;
    bit [7:0] m_buf, cur_txe;
    bit [7:0] mosi_b[4];
    bit [7:0] tx_b[4];
    bit       tx_w[4];
    bit       ack_mode;

    spi_slave_rx_tx #(.SYNC_STAGES(2), .DATA_W(8)) dut (
        .pclk(pclk), .preset(preset), .ss(ss), .sclk(sclk), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .cpol(cpol), .cpha(cpha), .lsbfe(lsbfe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
        .rx_overrun(rx_overrun), .ovr_clr(ovr_clr), .busy(busy)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge pclk);
    endtask

    function automatic void model_load();
        cur_txe = m_full ? m_buf : 8'h00;
        m_full  = 1'b0;
    endfunction

    task automatic write_tx(input bit [7:0] b);
        check("tx_ready_pre_write", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge pclk);
        tx_valid = 1'b0;
        m_full   = 1'b1;
        m_buf    = b;
        check("tx_ready_post_write", tx_ready, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_ready"}, tx_ready, 1);
        check({tag, "_rx_valid"}, rx_valid, 0);
        check({tag, "_rx_data"}, rx_data, 0);
        check({tag, "_overrun"}, rx_overrun, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_miso_oe"}, miso_oe, 0);
        check({tag, "_miso"}, miso, 0);
    endtask

    task automatic clear_rx();
        rx_ack  = 1'b1;
        ovr_clr = 1'b1;
        @(negedge pclk);
        rx_ack    = 1'b0;
        ovr_clr   = 1'b0;
        m_pending = 1'b0;
        m_ovr     = 1'b0;
    endtask

    // Runs exactly H cycles after each sample edge.
    task automatic post_sample(input int j, input int k);
        bit do_ack, do_clr;
        if (k == 7) begin
            wait_cyc(5);
            if (!dead_f) begin
                m_ovr     = m_ovr | m_pending;
                m_pending = 1'b1;
                model_load();
                check("rx_data", rx_data, mosi_b[j]);
            end
            check("rx_valid", rx_valid, m_pending);
            check("rx_overrun", rx_overrun, m_ovr);
            do_ack  = ack_mode && ($urandom_range(1) == 1);
            do_clr  = ack_mode && ($urandom_range(3) == 0);
            rx_ack  = do_ack;
            ovr_clr = do_clr;
            @(negedge pclk);
            rx_ack  = 1'b0;
            ovr_clr = 1'b0;
            if (do_ack) m_pending = 1'b0;
            if (do_clr) m_ovr = 1'b0;
        end else if (k == 2 && tx_w[j+1] && !dead_f) begin
            check("tx_ready_mid", tx_ready, !m_full);
            if (!m_full) begin
                write_tx(tx_b[j+1]);
                wait_cyc(H - 1);
            end else begin
                wait_cyc(H);
            end
        end else begin
            wait_cyc(H);
        end
    endtask

    task automatic run_frame(input bit cp, input bit ch, input bit lf, input int nb,
                             input int abort_at, input int rst_at);
        int  ns;
        bit  bt, exp_miso;
        ns     = 0;
        dead_f = 1'b0;
        $display("[TB] frame mode=%0d lsbfe=%0d bytes=%0d mosi=%h %h %h abort=%0d rst=%0d",
                 {cp, ch}, lf, nb, mosi_b[0], mosi_b[1], mosi_b[2], abort_at, rst_at);
        cpol = cp;
        cpha = ch;
        lsbfe = lf;
        sclk = cp;
        ss   = 1'b1;
        mosi = 1'b0;
        if (tx_w[0] && !m_full) write_tx(tx_b[0]);
        wait_cyc(H);
        ss = 1'b0;
        model_load();
        wait_cyc(H);
        check("busy_start", busy, 1);
        check("miso_oe_start", miso_oe, 1);
        check("tx_ready_start", tx_ready, !m_full);
        // Mode pins are latched at select fall; scrambling them now must have no effect.
        cpha  = 1'($urandom_range(1));
        lsbfe = 1'($urandom_range(1));
        for (int j = 0; j < nb; j++) begin
            for (int k = 0; k < 8; k++) begin
                bt = lf ? mosi_b[j][k] : mosi_b[j][7-k];
                if (!ch) begin
                    mosi = bt;
                    wait_cyc(H);
                    exp_miso = dead_f ? 1'b0 : (lf ? cur_txe[k] : cur_txe[7-k]);
                    check("miso_bit", miso, exp_miso);
                    sclk = ~cp;
                end else begin
                    sclk = ~cp;
                    mosi = bt;
                    wait_cyc(H);
                    exp_miso = dead_f ? 1'b0 : (lf ? cur_txe[k] : cur_txe[7-k]);
                    check("miso_bit", miso, exp_miso);
                    sclk = cp;
                end
                ns++;
                post_sample(j, k);
                if (ns == rst_at) begin
                    preset = 1'b1;
                    @(negedge pclk);
                    preset = 1'b0;
                    m_full = 1'b0;
                    m_pending = 1'b0;
                    m_ovr  = 1'b0;
                    dead_f = 1'b1;
                    check_reset_outputs("midreset");
                end
                if (ns == abort_at) begin
                    ss   = 1'b1;
                    sclk = cp;
                    wait_cyc(3);
                    check("abort_miso_oe", miso_oe, 0);
                    check("abort_busy", busy, 0);
                    check("abort_rx_valid", rx_valid, m_pending);
                    wait_cyc(H);
                    return;
                end
                if (!ch) sclk = cp;
            end
        end
        wait_cyc(H);
        ss = 1'b1;
        wait_cyc(3);
        check("end_miso_oe", miso_oe, 0);
        check("end_busy", busy, 0);
        check("end_miso", miso, 0);
        check("end_rx_valid", rx_valid, m_pending);
        wait_cyc(H);
    endtask

    task automatic clear_plan();
        for (int i = 0; i < 4; i++) begin
            tx_w[i]   = 1'b0;
            tx_b[i]   = 8'h00;
            mosi_b[i] = 8'h00;
        end
    endtask

    initial begin
        preset = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
        cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0; rx_ack = 1'b0; ovr_clr = 1'b0;
        ack_mode = 1'b0;
        m_full = 1'b0; m_pending = 1'b0; m_ovr = 1'b0; m_buf = 8'h00; cur_txe = 8'h00;
        wait_cyc(4);
        preset = 1'b0;
        check_reset_outputs("reset");

        // sclk activity with select high must not start anything
        for (int i = 0; i < 4; i++) begin
            sclk = ~sclk;
            wait_cyc(H);
        end
        check("idle_sclk_busy", busy, 0);
        check("idle_sclk_rx_valid", rx_valid, 0);
        sclk = 1'b0;

        clear_plan(); tx_w[0] = 1; tx_b[0] = 8'hA5; mosi_b[0] = 8'h3C;
        run_frame(0, 0, 0, 1, -1, -1);
        clear_rx();

        clear_plan(); tx_w[0] = 1; tx_b[0] = 8'hD5; mosi_b[0] = 8'hDA;
        run_frame(1, 1, 1, 1, -1, -1);
        clear_rx();

        clear_plan(); tx_w[0] = 1; tx_b[0] = 8'h55; tx_w[1] = 1; tx_b[1] = 8'h66;
        mosi_b[0] = 8'h11; mosi_b[1] = 8'h22;
        run_frame(0, 0, 0, 2, -1, -1);
        ovr_clr = 1'b1;
        @(negedge pclk);
        ovr_clr = 1'b0;
        check("ovr_clr_overrun", rx_overrun, 0);
        check("ovr_clr_rx_valid", rx_valid, 1);
        rx_ack = 1'b1;
        @(negedge pclk);
        rx_ack = 1'b0;
        check("ack_rx_valid", rx_valid, 0);
        m_pending = 1'b0; m_ovr = 1'b0;

        clear_plan(); mosi_b[0] = 8'($urandom);
        run_frame(0, 1, 0, 1, -1, -1);
        clear_rx();

        clear_plan(); mosi_b[0] = 8'hF0;
        run_frame(0, 0, 0, 1, 5, -1);
        clear_plan(); mosi_b[0] = 8'h81;
        run_frame(0, 0, 0, 1, -1, -1);
        clear_rx();

        clear_plan(); tx_w[0] = 1; tx_b[0] = 8'h3E; mosi_b[0] = 8'h96;
        run_frame(1, 0, 0, 1, -1, 3);
        clear_rx();

        ack_mode = 1'b1;
        for (int f = 0; f < 24; f++) begin
            int nb, ab, rs;
            clear_plan();
            nb = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) begin
                mosi_b[i] = 8'($urandom);
                tx_b[i]   = 8'($urandom);
                tx_w[i]   = 1'($urandom_range(1));
            end
            ab = ($urandom_range(3) == 0) ? int'($urandom_range(1, 8 * nb - 1)) : -1;
            rs = ($urandom_range(7) == 0) ? int'($urandom_range(1, 8 * nb)) : -1;
            run_frame(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                      nb, ab, rs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
